popcount_sequencer: RTL
=======================

POPCOUNT_SEQUENCER -- requirements
Module: popcount_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, input word width; SHALL be an integer multiple of CHUNK_WIDTH.
REQ-002 Parameter CHUNK_WIDTH, default 16, bits counted per cycle; NCHUNK = DATA_WIDTH/CHUNK_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 din_valid  input  1  input word offered.
REQ-006 din_ready  output  1  block can accept a word.
REQ-007 din  input  DATA_WIDTH  word to count.
REQ-008 dout_valid  output  1  result available.
REQ-009 dout_ready  input  1  consumer accepts result.
REQ-010 dout  output  $clog2(DATA_WIDTH)+1  number of set bits in the accepted word.
REQ-011 busy  output  1  high in COUNT or DONE.

Function
REQ-012 FSM states SHALL be IDLE, COUNT and DONE; reset state is IDLE.
REQ-013 IDLE: din_ready=1, dout_valid=0, busy=0; on din_valid&&din_ready, register din into a shift register, clear accumulator, chunk index=0, go to COUNT.
REQ-014 COUNT: each cycle, add popcount of shift register bits [CHUNK_WIDTH-1:0] to accumulator, shift register right by CHUNK_WIDTH, increment chunk index.
REQ-015 COUNT SHALL exit to DONE after the chunk with index NCHUNK-1 is added, except as modified by REQ-025.
REQ-016 DONE: dout_valid=1, dout=accumulator; dout and dout_valid SHALL be held stable until dout_ready=1.
REQ-017 On dout_valid&&dout_ready, go to IDLE next cycle; no new word is accepted in that same cycle.
REQ-018 din_ready SHALL be 0 in COUNT and DONE; din and din_valid are ignored there.
REQ-019 Latency (macro off): handshake at cycle T -> dout_valid first high at T+NCHUNK+1.
REQ-020 Accumulator and dout width $clog2(DATA_WIDTH)+1; all-ones input SHALL yield exactly DATA_WIDTH with no overflow.
REQ-021 dout SHALL be 0 whenever dout_valid=0.

Reset
REQ-022 When reset=1 at a rising edge: state=IDLE, accumulator=0, shift register=0, chunk index=0, dout_valid=0, dout=0, busy=0, din_ready=1 from the following cycle.
REQ-023 Reset in COUNT or DONE SHALL abort the operation; the partial result is discarded and never presented.
REQ-024 Reset has priority over any simultaneous handshake.

Configuration
REQ-025 Macro POPCOUNT_SEQUENCER_EARLY_EXIT_EN defined: COUNT also exits to DONE after any cycle in which the post-shift remainder is zero; COUNT lasts (index of highest nonzero chunk)+1 cycles, minimum 1 (all-zero word: 1 cycle).
REQ-026 Macro undefined: COUNT always lasts exactly NCHUNK cycles regardless of data; dout values are identical in both builds.

Verification (DATA_WIDTH=64, CHUNK_WIDTH=16)
REQ-027 din=64'h0 accepted at T, dout_ready=1 -> dout_valid at T+5 (macro off) / T+2 (macro on), dout=0.
REQ-028 din=64'hFFFF_FFFF_FFFF_FFFF -> dout=64 at T+5 in both builds.
REQ-029 din=64'h8000_0000_0000_0001 -> dout=2 at T+5 in both builds; din=64'h0000_0000_0000_00FF with macro on -> dout=8 at T+2.
REQ-030 Result pending, dout_ready=0 for 5 cycles -> dout_valid=1 and dout constant all 5 cycles, din_ready=0; dout_ready=1 -> IDLE and din_ready=1 next cycle.
REQ-031 reset=1 during second COUNT cycle -> next cycle dout_valid=0, dout=0, busy=0, din_ready=1; word 64'h3 then yields dout=2.
REQ-032 din_valid held high across back-to-back words 64'hF and 64'hFF -> results 4 then 8 in order, second accepted only after IDLE reentry.

Source files
------------

// File: rtl/popcount_sequencer.sv
// rtl/popcount_sequencer.sv - multi-cycle popcount, one CHUNK_WIDTH slice per cycle
// Optional build macro POPCOUNT_SEQUENCER_EARLY_EXIT_EN ends counting once the remaining word is zero.
module popcount_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(DATA_WIDTH):0]   dout,
    output logic                          busy
);
    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int OUT_W  = $clog2(DATA_WIDTH) + 1;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [OUT_W-1:0]        r_acc;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic [OUT_W-1:0]        w_chunk_cnt;
    logic                    w_last;

    assign w_shift_next = r_shift >> CHUNK_WIDTH;

    always_comb begin
        w_chunk_cnt = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            w_chunk_cnt = w_chunk_cnt + OUT_W'(r_shift[i]);
        end
    end

`ifdef POPCOUNT_SEQUENCER_EARLY_EXIT_EN
    assign w_last = (r_idx == IDX_W'(NCHUNK - 1)) || (w_shift_next == '0);
`else
    assign w_last = (r_idx == IDX_W'(NCHUNK - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (din_valid) begin
                        r_shift <= din;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_COUNT: begin
                    r_shift <= w_shift_next;
                    r_acc   <= r_acc + w_chunk_cnt;
                    r_idx   <= r_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (din_valid)  w_next_state = S_COUNT;
            S_COUNT: if (w_last)     w_next_state = S_DONE;
            S_DONE:  if (dout_ready) w_next_state = S_IDLE;
            default:                 w_next_state = S_IDLE;
        endcase
    end

    // Result is forced to zero outside DONE so partial sums never leak out.
    assign din_ready  = (r_state == S_IDLE);
    assign dout_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign dout       = (r_state == S_DONE) ? r_acc : '0;

endmodule
